apb_master: RTL and testbench

- Bus controller between the CPU_RV32I data-bus port (busWe/busAddr/busWData/busRData) and an APB-style peripheral bus.
- Sequences each CPU load/store into a two-phase SETUP/ACCESS transfer and decodes the address to one of NUM_SLV slaves (RAM, GPO, GPI, UART).
- Stalls the CPU until the slave responds, the access times out, or the address decodes to nothing.
- Sits inside MCU, replacing the direct CPU-to-RAM wiring.

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_addr_decoder.sv | 33 +++
 rtl/apb_master.sv | 142 ++++++++++++++
 tb/tb_apb_master.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and address-map defaults for the CPU-to-APB bus controller.
// Imported by the master and by anything that needs the slave map.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DECERR
    } apbStateT;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;
    localparam int          DEFAULT_SLV_AW    = 12;

    // Slave slots in the MCU address map
    localparam int RAM  = 0;
    localparam int GPO  = 1;
    localparam int GPI  = 2;
    localparam int UART = 3;

    // Index width that stays legal for a single-slave bus
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: maps a byte address onto one of NUM_SLV
// equally sized windows starting at BASE_ADDR.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          SLV_AW    = DEFAULT_SLV_AW,
    localparam int         IDX_W     = idxWidth(NUM_SLV)
) (
    input  logic [31:0]        busAddr,
    output logic               hit,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_SLV-1:0] sel
);

    logic [31:0] offset;
    logic [31:0] window;

    // Below-base addresses wrap the subtraction, so the >= test rejects them
    assign offset = busAddr - BASE_ADDR;
    assign window = offset >> SLV_AW;
    assign hit    = (busAddr >= BASE_ADDR) && (window < 32'(NUM_SLV));
    assign idx    = window[IDX_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : gSel
            assign sel[gi] = hit && (window == 32'(gi));
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// Turns each CPU load/store into an APB SETUP/ACCESS transfer, stalling the
// CPU until the selected slave answers, the access times out, or decode fails.
module apb_master
    import apb_pkg::*;
#(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          SLV_AW    = DEFAULT_SLV_AW,
    parameter int          TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  transfer,
    input  logic                  busWe,
    input  logic [31:0]           busAddr,
    input  logic [31:0]           busWData,
    output logic [31:0]           busRData,
    output logic                  ready,
    output logic                  err,
    output logic [31:0]           PADDR,
    output logic [31:0]           PWDATA,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [NUM_SLV-1:0]    PSEL,
    input  logic [NUM_SLV*32-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]    PREADY
);

    localparam int             IDX_W    = idxWidth(NUM_SLV);
    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apbStateT             stateReg, stateNext;
    logic [NUM_SLV-1:0]   selReg;
    logic [IDX_W-1:0]     idxReg;
    logic [CNT_W-1:0]     cntReg;
    logic [31:0]          paddrReg;
    logic [31:0]          pwdataReg;
    logic                 pwriteReg;

    logic                 decHit;
    logic [IDX_W-1:0]     decIdx;
    logic [NUM_SLV-1:0]   decSel;
    logic [31:0]          prdataSlot [NUM_SLV];
    logic                 slvReady;
    logic [31:0]          slvData;

    apb_addr_decoder #(
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE_ADDR),
        .SLV_AW    (SLV_AW)
    ) uDecoder (
        .busAddr (busAddr),
        .hit     (decHit),
        .idx     (decIdx),
        .sel     (decSel)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : gSlot
            assign prdataSlot[gi] = PRDATA[gi*32 +: 32];
        end
    endgenerate

    // Only the latched slave's handshake matters; the others are ignored
    assign slvReady = PREADY[idxReg];
    assign slvData  = prdataSlot[idxReg];

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg  <= IDLE;
            selReg    <= '0;
            idxReg    <= '0;
            cntReg    <= '0;
            paddrReg  <= '0;
            pwdataReg <= '0;
            pwriteReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: begin
                    if (transfer && decHit) begin
                        paddrReg  <= busAddr;
                        pwdataReg <= busWData;
                        pwriteReg <= busWe;
                        selReg    <= decSel;
                        idxReg    <= decIdx;
                    end
                end
                SETUP:   cntReg <= '0;
                ACCESS:  cntReg <= cntReg + CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = stateReg;
        ready     = 1'b0;
        err       = 1'b0;
        busRData  = '0;
        case (stateReg)
            IDLE: begin
                if (transfer) begin
                    stateNext = decHit ? SETUP : DECERR;
                end
            end
            SETUP: stateNext = ACCESS;
            ACCESS: begin
                // A PREADY arriving on the last allowed cycle still completes cleanly
                if (slvReady) begin
                    ready     = 1'b1;
                    busRData  = pwriteReg ? 32'h0 : slvData;
                    stateNext = IDLE;
                end else if (cntReg == CNT_LAST) begin
                    ready     = 1'b1;
                    err       = 1'b1;
                    stateNext = IDLE;
                end
            end
            DECERR: begin
                ready     = 1'b1;
                err       = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (!reset) begin
            ready    = 1'b0;
            err      = 1'b0;
            busRData = '0;
        end
    end

    assign PSEL    = (stateReg == SETUP || stateReg == ACCESS) ? selReg : '0;
    assign PENABLE = (stateReg == ACCESS);
    assign PADDR   = paddrReg;
    assign PWDATA  = pwdataReg;
    assign PWRITE  = pwriteReg;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table, randomized transfers checked
// against an address-map/latency model, and a reset-abort sequence.
module tb_apb_master;

    localparam int          NSLV = 4;
    localparam int          TMO  = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          WIN  = 4096;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 transfer;
    logic                 busWe;
    logic [31:0]          busAddr;
    logic [31:0]          busWData;
    logic [31:0]          busRData;
    logic                 ready;
    logic                 err;
    logic [31:0]          PADDR;
    logic [31:0]          PWDATA;
    logic                 PWRITE;
    logic                 PENABLE;
    logic [NSLV-1:0]      PSEL;
    logic [NSLV*32-1:0]   PRDATA;
    logic [NSLV-1:0]      PREADY;

    int checks = 0;
    int errors = 0;
    int txnNum = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        int          expLat;
        logic        expErr;
        logic [31:0] expData;
        logic [3:0]  expSel;
    } vec_t;

    vec_t vecs [12];

    apb_master #(
        .NUM_SLV   (NSLV),
        .BASE_ADDR (BASE),
        .SLV_AW    (12),
        .TIMEOUT   (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .transfer (transfer),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .busWData (busWData),
        .busRData (busRData),
        .ready    (ready),
        .err      (err),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: window arithmetic on a 64-bit offset, then latency from the wait count
    function automatic vec_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int waits,
                                   input logic [31:0] prdata);
        vec_t   v;
        longint off;
        int     slot;
        v.we = we; v.addr = addr; v.wdata = wdata; v.waits = waits; v.prdata = prdata;
        v.expLat = 1; v.expErr = 1'b1; v.expData = 32'h0; v.expSel = 4'h0;
        off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
        if (off >= 0 && (off / WIN) < NSLV) begin
            slot     = int'(off / WIN);
            v.expSel = 4'(1 << slot);
            if (waits < TMO) begin
                v.expLat  = 2 + waits;
                v.expErr  = 1'b0;
                v.expData = we ? 32'h0 : prdata;
            end else begin
                v.expLat = 1 + TMO;
            end
        end
        return v;
    endfunction

    task automatic applyVec(input vec_t v);
        int          lat;
        logic        gotErr;
        logic [31:0] gotData;
        int          phaseBad;
        int          latchBad;
        string       tag;
        lat = -1; gotErr = 1'b0; gotData = 32'h0; phaseBad = 0; latchBad = 0;
        tag = $sformatf("txn%0d", txnNum);

        // Transfer cycle: the controller must be idle here
        @(posedge clk); #1;
        transfer = 1'b1;
        busWe    = v.we;
        busAddr  = v.addr;
        busWData = v.wdata;
        for (int s = 0; s < NSLV; s++)
            PRDATA[s*32 +: 32] = v.expSel[s] ? v.prdata : $urandom;
        PREADY = ((v.waits == 0) ? v.expSel : 4'h0) | (4'($urandom) & ~v.expSel);
        @(negedge clk);
        check({tag, "_idle"}, {29'h0, ready, PENABLE, |PSEL}, 32'h0);

        for (int c = 1; c <= TMO + 8 && lat < 0; c++) begin
            @(posedge clk); #1;
            transfer = 1'b0;
            PREADY = ((c >= v.waits + 2 || v.waits == 0) ? v.expSel : 4'h0)
                     | (4'($urandom) & ~v.expSel);
            @(negedge clk);
            if (PSEL !== v.expSel || PENABLE !== ((v.expSel != 4'h0) && (c >= 2)))
                phaseBad++;
            if (c == 1 && v.expSel != 4'h0 &&
                (PADDR !== v.addr || PWDATA !== v.wdata || PWRITE !== v.we))
                latchBad++;
            if (ready === 1'b1) begin
                lat     = c;
                gotErr  = err;
                gotData = busRData;
            end
        end

        check({tag, "_latency"}, 32'(lat), 32'(v.expLat));
        check({tag, "_err"}, {31'h0, gotErr}, {31'h0, v.expErr});
        check({tag, "_rdata"}, gotData, v.expData);
        check({tag, "_phase"}, 32'(phaseBad), 32'h0);
        if (v.expSel != 4'h0)
            check({tag, "_latch"}, 32'(latchBad), 32'h0);
        $display("%s we=%0d addr=%08h lat=%0d err=%0d rdata=%08h", tag, v.we, v.addr, lat, gotErr, gotData);
        txnNum++;
    endtask

    initial begin
        vec_t rv;
        logic [31:0] a;
        int kind;

        vecs[0]  = '{1'b1, 32'h1000_0004, 32'hCAFE_F00D, 0,   32'h1111_1111, 2, 1'b0, 32'h0,          4'b0001};
        vecs[1]  = '{1'b0, 32'h1000_2000, 32'h0,         3,   32'h0000_00A5, 5, 1'b0, 32'h0000_00A5,  4'b0100};
        vecs[2]  = '{1'b0, 32'h2000_0000, 32'h0,         0,   32'h0,         1, 1'b1, 32'h0,          4'b0000};
        vecs[3]  = '{1'b0, 32'h0FFF_FFFC, 32'h0,         0,   32'h0,         1, 1'b1, 32'h0,          4'b0000};
        vecs[4]  = '{1'b1, 32'h1000_3010, 32'h5555_AAAA, 100, 32'h7777_7777, 5, 1'b1, 32'h0,          4'b1000};
        vecs[5]  = '{1'b0, 32'h1000_3000, 32'h0,         3,   32'h1234_5678, 5, 1'b0, 32'h1234_5678,  4'b1000};
        vecs[6]  = '{1'b1, 32'h1000_0100, 32'hDEAD_BEEF, 0,   32'h2222_2222, 2, 1'b0, 32'h0,          4'b0001};
        vecs[7]  = '{1'b0, 32'h1000_1008, 32'h0,         1,   32'h5A5A_0001, 3, 1'b0, 32'h5A5A_0001,  4'b0010};
        vecs[8]  = '{1'b0, 32'h1000_3FFC, 32'h0,         0,   32'h0BAD_BEEF, 2, 1'b0, 32'h0BAD_BEEF,  4'b1000};
        vecs[9]  = '{1'b0, 32'h1000_4000, 32'h0,         0,   32'h0,         1, 1'b1, 32'h0,          4'b0000};
        vecs[10] = '{1'b0, 32'h1000_2ABC, 32'h0,         4,   32'h3333_3333, 5, 1'b1, 32'h0,          4'b0100};
        vecs[11] = '{1'b1, 32'h0000_0000, 32'h1,         0,   32'h0,         1, 1'b1, 32'h0,          4'b0000};

        reset = 1'b0; transfer = 1'b0; busWe = 1'b0; busAddr = 32'h0; busWData = 32'h0;
        PRDATA = '0; PREADY = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_rdata", busRData, 32'h0);
        check("rst_psel", {28'h0, PSEL}, 32'h0);
        check("rst_penable", {31'h0, PENABLE}, 32'h0);
        check("rst_pwrite", {31'h0, PWRITE}, 32'h0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 12; i++)
            applyVec(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0, 1, 2: a = BASE + 32'($urandom_range(0, NSLV - 1) * WIN) + 32'($urandom_range(0, WIN - 1));
                3:       a = BASE - 32'($urandom_range(1, 64));
                default: a = BASE + 32'(NSLV * WIN) + 32'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 7) == 0)
                a = $urandom;
            rv = model(1'($urandom), a, $urandom, $urandom_range(0, 6), $urandom);
            applyVec(rv);
        end

        // Reset asserted in the second ACCESS cycle of a stalled UART store
        @(posedge clk); #1;
        transfer = 1'b1; busWe = 1'b1; busAddr = 32'h1000_3000; busWData = 32'h0F0F_0F0F; PREADY = '0;
        @(posedge clk); #1;
        transfer = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_access1", {27'h0, PENABLE, PSEL}, {27'h0, 1'b1, 4'b1000});
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_noready", {31'h0, ready}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_bus", {26'h0, ready, err, PENABLE, PSEL}, 32'h0);
        check("abort_paddr", PADDR, 32'h0);
        check("abort_pwrite", {31'h0, PWRITE}, 32'h0);
        applyVec('{1'b1, 32'h1000_0010, 32'hA5A5_5A5A, 1, 32'h4444_4444, 3, 1'b0, 32'h0, 4'b0001});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
